cordic_result_fifo: RTL and testbench
=====================================

CORDIC_RESULT_FIFO -- requirements
Module: cordic_result_fifo

Interface
REQ-001 Parameter DATA_W, default 32, result word width.
REQ-002 Parameter DEPTH, default 8, number of storage entries; SHALL be a power of two, at least 2.
REQ-003 Parameter ADDR_W, default 3, pointer width; SHALL equal log2(DEPTH).
REQ-004 HCLK  input  1  single clock; all state updates on its rising edge.
REQ-005 HRESETn  input  1  reset, synchronous, active-low.
REQ-006 wr_en  input  1  CORDIC result valid; one result per asserted cycle.
REQ-007 din  input  DATA_W  CORDIC result word.
REQ-008 rd_en  input  1  bus-side read request; consumes the head word.
REQ-009 dout  output  DATA_W  head word, first-word fall-through.
REQ-010 empty  output  1  no stored words.
REQ-011 full  output  1  DEPTH words stored.
REQ-012 count  output  ADDR_W+1  number of stored words, 0..DEPTH.
REQ-013 overflow  output  1  sticky: a write was dropped.
REQ-014 underflow  output  1  sticky: a read found no data.
REQ-015 flags_clr  input  1  clears overflow and underflow.

Function
REQ-016 empty SHALL be 1 exactly when count==0; full SHALL be 1 exactly when count==DEPTH; both registered, not derived from inputs.
REQ-017 avail = !empty || wr_en; rd_acc = rd_en && avail; wr_acc = wr_en && (!full || rd_acc).
REQ-018 dout SHALL be mem[rd_ptr] when !empty, din when empty && wr_en (bypass), else all zeros; combinational, zero added latency.
REQ-019 Write-to-dout latency: same cycle via bypass when empty; otherwise the word appears at head once all older words are consumed.
REQ-020 wr_acc && !rd_acc: store din at wr_ptr, wr_ptr+1, count+1.
REQ-021 rd_acc && !wr_acc: rd_ptr+1, count-1.
REQ-022 wr_acc && rd_acc && !empty: store din, both pointers +1, count unchanged (also when full).
REQ-023 wr_acc && rd_acc && empty: bypass; word delivered on dout, nothing stored, pointers and count unchanged.
REQ-024 wr_en && full && !rd_en: word dropped, state unchanged, overflow set next cycle.
REQ-025 rd_en && !avail: no state change, dout zero, underflow set next cycle.
REQ-026 Pointers SHALL wrap DEPTH-1 -> 0 with no gap or lost word.
REQ-027 flags_clr SHALL clear both stickies next cycle; a new overflow/underflow event in the same cycle SHALL win (flag stays 1).
REQ-028 Data SHALL leave in strict write order; no word duplicated, reordered, or lost except per REQ-024.

Reset
REQ-029 HRESETn low at an edge: rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, overflow=0, underflow=0; stored contents discarded, memory array need not be cleared.
REQ-030 Reset mid-operation SHALL take priority over any simultaneous wr_en/rd_en/flags_clr; first post-reset word SHALL enter via bypass/slot 0.

Structure
REQ-031 DATA_W default and the CORDIC result word width constant SHALL live in the shared cordic package used by the bus slave and CORDIC core.
REQ-032 Storage SHALL be one sub-module, cordic_fifo_mem: DEPTH x DATA_W, one synchronous write port, one combinational read port; pointers, count, flags and bypass stay in the parent.

Verification
REQ-033 Reset, then wr_en=1 din=0x0000_1234 with rd_en=1 same cycle -> dout=0x0000_1234 that cycle, count stays 0, empty stays 1.
REQ-034 Write 0x1..0x8 on 8 cycles, no reads -> full=1, count=8, dout=0x1; 9th write 0x9 -> dropped, overflow=1, count=8.
REQ-035 From full, wr_en=1 din=0xA and rd_en=1 together -> count=8, dout advances to 0x2, 0xA later read after 0x8.
REQ-036 Stream 20 words with reads interleaved at 50% duty -> reads return 0..19 in order, pointers wrap twice, no loss.
REQ-037 rd_en=1 while empty and wr_en=0 -> dout=0, underflow=1; then flags_clr=1 -> underflow=0; flags_clr with simultaneous underflow -> underflow stays 1.
REQ-038 Hold HRESETn low for one cycle with count=5 and wr_en=rd_en=1 -> next cycle count=0, empty=1, flags 0.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: result word width and FIFO operation encoding
// used by the bus slave, the CORDIC core and the result FIFO.
package cordic_pkg;

    localparam int unsigned CORDIC_RESULT_W = 32;
    localparam int unsigned CORDIC_DATA_W   = CORDIC_RESULT_W;

    typedef enum logic [1:0] {
        FIFO_IDLE     = 2'b00,
        FIFO_PUSH     = 2'b01,
        FIFO_POP      = 2'b10,
        FIFO_PUSH_POP = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic store, input logic pop);
        return fifo_op_e'({pop, store});
    endfunction

endpackage

// File: rtl/cordic_fifo_mem.sv
// Result FIFO storage: DEPTH x DATA_W, one synchronous write port and one
// combinational read port.
module cordic_fifo_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cordic_result_fifo.sv
// First-word fall-through FIFO buffering CORDIC results for the bus side,
// with empty-bypass and sticky overflow/underflow flags.
module cordic_result_fifo
    import cordic_pkg::*;
#(
    parameter int unsigned DATA_W = CORDIC_DATA_W,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              flags_clr
);

    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, full_q;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              avail, rd_acc, wr_acc, bypass, store, pop;
    logic [DATA_W-1:0] mem_rdata;

    assign avail  = !empty_q || wr_en;
    assign rd_acc = rd_en && avail;
    assign wr_acc = wr_en && (!full_q || rd_acc);
    // A read and write meeting on an empty FIFO pass straight through.
    assign bypass = empty_q && wr_acc && rd_acc;
    assign store  = wr_acc && !bypass;
    assign pop    = rd_acc && !bypass;

    cordic_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (HCLK),
        .we_i    (store),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (store) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case (fifo_op(store, pop))
            FIFO_PUSH: count_d = count_q + (ADDR_W+1)'(1);
            FIFO_POP:  count_d = count_q - (ADDR_W+1)'(1);
            default:   count_d = count_q;
        endcase
        // A fresh event in the clearing cycle keeps its flag set.
        ovf_d = (wr_en && !wr_acc) || (ovf_q && !flags_clr);
        udf_d = (rd_en && !avail)  || (udf_q && !flags_clr);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == (ADDR_W+1)'(DEPTH));
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_comb begin
        if (!empty_q) begin
            dout = mem_rdata;
        end else if (wr_en) begin
            dout = din;
        end else begin
            dout = '0;
        end
    end

    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_cordic_result_fifo.sv
// Self-checking bench for cordic_result_fifo: queue-based reference model,
// a hand-derived vector table and directed multi-cycle sequences.
module tb_cordic_result_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          wr_en, rd_en, flags_clr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          empty, full, overflow, underflow;
    logic [AW:0]   count;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mq[$];
    logic          m_ovf, m_udf;
    int            reads_seen;

    cordic_result_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .wr_en     (wr_en),
        .din       (din),
        .rd_en     (rd_en),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .flags_clr (flags_clr)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        wr_en     = w;
        din       = d;
        rd_en     = r;
        flags_clr = c;
    endtask

    // Called #1 after inputs settle: compare DUT to model, advance model, clock.
    task automatic model_and_clock();
        logic [DW-1:0] exp_dout;
        logic          avail, racc, wacc;
        int            sz;
        sz = mq.size();
        if (sz > 0)     exp_dout = mq[0];
        else if (wr_en) exp_dout = din;
        else            exp_dout = '0;
        check("dout",      dout,           exp_dout);
        check("count",     DW'(count),     DW'(sz));
        check("empty",     DW'(empty),     DW'(sz == 0));
        check("full",      DW'(full),      DW'(sz == DEPTH));
        check("overflow",  DW'(overflow),  DW'(m_ovf));
        check("underflow", DW'(underflow), DW'(m_udf));
        avail = (sz > 0) || wr_en;
        racc  = rd_en && avail;
        wacc  = wr_en && ((sz < DEPTH) || racc);
        if (racc) reads_seen++;
        if (racc && sz > 0) void'(mq.pop_front());
        if (wacc && !(racc && sz == 0)) mq.push_back(din);
        m_ovf = (wr_en && !wacc) || (m_ovf && !flags_clr);
        m_udf = (rd_en && !avail) || (m_udf && !flags_clr);
        @(posedge HCLK);
        #1;
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        set_in(w, d, r, c);
        #1;
        model_and_clock();
    endtask

    task automatic apply_reset(input logic w, input logic r);
        HRESETn = 1'b0;
        set_in(w, 32'hDEAD_BEEF, r, 1'b0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0);
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        check("rst_count",     DW'(count),     '0);
        check("rst_empty",     DW'(empty),     DW'(1));
        check("rst_full",      DW'(full),      '0);
        check("rst_overflow",  DW'(overflow),  '0);
        check("rst_underflow", DW'(underflow), '0);
    endtask

    typedef struct {
        logic          w;
        logic [DW-1:0] d;
        logic          r;
        logic          c;
        logic [DW-1:0] exp_dout;
        logic [AW:0]   exp_cnt;
        logic          exp_udf;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // {wr, din, rd, clr, dout this cycle, count after, underflow after}
        tbl[0]  = '{1'b1, 32'h0000_1234, 1'b1, 1'b0, 32'h0000_1234, 4'd0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         4'd0, 1'b1};
        tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         4'd0, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         4'd0, 1'b1};
        tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         4'd0, 1'b0};
        tbl[5]  = '{1'b1, 32'hAA,        1'b0, 1'b0, 32'hAA,        4'd1, 1'b0};
        tbl[6]  = '{1'b1, 32'hBB,        1'b0, 1'b0, 32'hAA,        4'd2, 1'b0};
        tbl[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hAA,        4'd1, 1'b0};
        tbl[8]  = '{1'b1, 32'hCC,        1'b1, 1'b0, 32'hBB,        4'd1, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hCC,        4'd0, 1'b0};
        tbl[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         4'd0, 1'b0};

        HRESETn = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0);
        m_ovf = 1'b0;
        m_udf = 1'b0;
        reads_seen = 0;
        repeat (2) @(posedge HCLK);
        #1;
        apply_reset(1'b0, 1'b0);

        // Bypass, underflow, flag clear and clear-vs-event priority
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
            #1;
            check($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
            model_and_clock();
            check($sformatf("tbl%0d_count", i), DW'(count), DW'(tbl[i].exp_cnt));
            check($sformatf("tbl%0d_udf", i), DW'(underflow), DW'(tbl[i].exp_udf));
        end

        // Fill to full, overflow drop, simultaneous read+write while full
        apply_reset(1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        check("fill_full",  DW'(full),  DW'(1));
        check("fill_count", DW'(count), DW'(8));
        check("fill_dout",  dout,       DW'(1));
        step(1'b1, 32'h9, 1'b0, 1'b0);
        check("ovf_set",   DW'(overflow), DW'(1));
        check("ovf_count", DW'(count),    DW'(8));
        step(1'b1, 32'h9, 1'b0, 1'b1);
        check("ovf_clr_event_wins", DW'(overflow), DW'(1));
        step(1'b1, 32'hA, 1'b1, 1'b0);
        check("full_rw_count", DW'(count), DW'(8));
        check("full_rw_dout",  dout,       DW'(2));
        step(1'b0, '0, 1'b0, 1'b1);
        check("ovf_cleared", DW'(overflow), '0);
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            #1;
            check("drain_order", dout, (i < 7) ? DW'(i + 2) : DW'(32'hA));
            model_and_clock();
        end
        check("drain_empty", DW'(empty), DW'(1));

        // 20-word stream, reads at 50% duty, pointers wrap
        apply_reset(1'b0, 1'b0);
        reads_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) step(1'b1, DW'(i / 2), 1'b0, 1'b0);
            else            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("stream_reads", DW'(reads_seen), DW'(20));
        check("stream_empty", DW'(empty),      DW'(1));

        // Mid-operation reset with count=5 and flags set
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, DW'(32'h50 + i), 1'b0, 1'b0);
        check("pre_rst_count", DW'(count),     DW'(5));
        check("pre_rst_udf",   DW'(underflow), DW'(1));
        apply_reset(1'b1, 1'b1);
        set_in(1'b1, 32'h77, 1'b0, 1'b0);
        #1;
        check("post_rst_bypass", dout, 32'h77);
        model_and_clock();
        step(1'b0, '0, 1'b0, 1'b0);
        check("post_rst_head", dout, 32'h77);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
